// File: rtl/mem_port_arbiter_if.sv
// Bus bundle joining the pipeline requesters, the RAM wrapper and mem_port_arbiter.
// The arbiter takes the slave view; the pipeline/RAM side takes the master view.
interface mem_port_arbiter_if #(
  parameter int RAM_AW = 12
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [31:0]       ls_addr;
  logic [31:0]       ls_din;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;
  logic              fetch_stall;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_din, ram_dout,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           fetch_stall, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_din, ram_dout,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           fetch_stall, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: load/store has priority, fetch is forced through after
// STARVE_LIMIT consecutive denials; read data is steered back one cycle later.
//
// state    | meaning
// OWN_NONE | no read response due this cycle
// OWN_IF   | fetch read issued last cycle, ram_dout belongs to fetch
// OWN_LS   | load issued last cycle, ram_dout belongs to load/store stage
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_AW       = 12
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t      owner;
  owner_t      owner_nxt;
  logic [3:0]  starve_cnt;
  logic        if_gnt;
  logic        ls_gnt;
  logic        if_rvalid;
  logic        ls_rvalid;
  logic [31:0] if_hold;
  logic [31:0] ls_hold;
  logic [31:0] sel_addr;
  logic        unused_addr_bits;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst) begin
      if (bus.if_req && (starve_cnt == LIMIT)) begin
        if_gnt = 1'b1;
      end else if (bus.ls_req) begin
        ls_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign sel_addr         = ls_gnt ? bus.ls_addr : bus.if_addr;
  assign unused_addr_bits = ^{sel_addr[31:RAM_AW+2], sel_addr[1:0]};

  assign bus.if_gnt      = if_gnt;
  assign bus.ls_gnt      = ls_gnt;
  assign bus.fetch_stall = bus.if_req & ~if_gnt;
  assign bus.ram_en      = if_gnt | ls_gnt;
  assign bus.ram_we      = ls_gnt & bus.ls_we;
  assign bus.ram_addr    = sel_addr[RAM_AW+1:2];
  assign bus.ram_din     = ls_gnt ? bus.ls_din : 32'd0;

  // Counts consecutive fetch denials; sticks at the limit until fetch wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (ls_gnt && !bus.ls_we) begin
      owner_nxt = OWN_LS;
    end
  end

  // A reset landing on the response cycle suppresses the response.
  always_comb begin
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if (rst) begin
      if_rvalid = (owner == OWN_IF);
      ls_rvalid = (owner == OWN_LS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_hold <= 32'd0;
      ls_hold <= 32'd0;
    end else begin
      if (if_rvalid) if_hold <= bus.ram_dout;
      if (ls_rvalid) ls_hold <= bus.ram_dout;
    end
  end

  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.ram_dout : if_hold;
  assign bus.ls_rdata  = ls_rvalid ? bus.ram_dout : ls_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, then random traffic checked
// against a transaction-level model with its own copy of RAM contents.
module tb_mem_port_arbiter;

  localparam int LIMIT  = 4;
  localparam int RAM_AW = 12;
  localparam int NWORDS = 4096;
  localparam int NRAND  = 1500;

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        lsr;
    logic        lswe;
    logic [31:0] lsa;
    logic [31:0] ld;
    logic        e_ifg;
    logic        e_lsg;
    logic        e_stall;
    logic        e_en;
    logic        e_we;
    logic        chk_addr;
    logic [11:0] e_addr;
    logic [31:0] e_din;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
    logic        chk_rd;
  } vec_t;

  logic clk;
  logic rst;
  logic mem_ready = 1'b0;
  int   checks    = 0;
  int   failures  = 0;

  logic [31:0] ram_mem   [NWORDS];
  logic [31:0] model_mem [NWORDS];
  int          m_den;
  int          m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] m_if_hold;
  logic [31:0] m_ls_hold;
  vec_t        tbl [25];

  mem_port_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .RAM_AW(RAM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h0100_2223 : (32'hA500_0000 | 32'(i));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % NWORDS);
  endfunction

  // RAM wrapper stand-in: synchronous write, registered read.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < NWORDS; i++) ram_mem[i] <= init_word(i);
      bus.ram_dout <= 32'd0;
      mem_ready    <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input int r, input int ifr, input logic [31:0] ifa,
                             input int lsr, input int lswe, input logic [31:0] lsa,
                             input logic [31:0] ld, input int ifg, input int lsg,
                             input int stall, input int en, input int we, input int addr,
                             input logic [31:0] din, input int ifv, input logic [31:0] ifd,
                             input int lsv, input logic [31:0] lrd);
    vec_t t;
    t.rst      = (r != 0);
    t.ifr      = (ifr != 0);
    t.ifa      = ifa;
    t.lsr      = (lsr != 0);
    t.lswe     = (lswe != 0);
    t.lsa      = lsa;
    t.ld       = ld;
    t.e_ifg    = (ifg != 0);
    t.e_lsg    = (lsg != 0);
    t.e_stall  = (stall != 0);
    t.e_en     = (en != 0);
    t.e_we     = (we != 0);
    t.chk_addr = (addr >= 0);
    t.e_addr   = (addr >= 0) ? 12'(addr) : 12'd0;
    t.e_din    = din;
    t.e_ifv    = (ifv != 0);
    t.e_ifd    = ifd;
    t.e_lsv    = (lsv != 0);
    t.e_lsd    = lrd;
    t.chk_rd   = 1'b1;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst         = t.rst;
    bus.if_req  = t.ifr;
    bus.if_addr = t.ifa;
    bus.ls_req  = t.lsr;
    bus.ls_we   = t.lswe;
    bus.ls_addr = t.lsa;
    bus.ls_din  = t.ld;
  endtask

  // Fetch wins when starved or when load/store is idle; nothing wins during reset.
  task automatic model_grant(output logic gi, output logic gl);
    gi = 1'b0;
    gl = 1'b0;
    if (rst) begin
      if (bus.if_req && (m_den == LIMIT || !bus.ls_req)) gi = 1'b1;
      else if (bus.ls_req)                                gl = 1'b1;
    end
  endtask

  task automatic model_step();
    logic gi, gl;
    if (!rst) begin
      m_den     = 0;
      m_pend    = 0;
      m_if_hold = 32'd0;
      m_ls_hold = 32'd0;
    end else begin
      model_grant(gi, gl);
      if (m_pend == 1) m_if_hold = m_pend_data;
      if (m_pend == 2) m_ls_hold = m_pend_data;
      m_pend = 0;
      if (gi) begin
        m_pend      = 1;
        m_pend_data = model_mem[widx(bus.if_addr)];
      end else if (gl) begin
        if (bus.ls_we) begin
          model_mem[widx(bus.ls_addr)] = bus.ls_din;
        end else begin
          m_pend      = 2;
          m_pend_data = model_mem[widx(bus.ls_addr)];
        end
      end
      if (bus.if_req && !gi) m_den = (m_den < LIMIT) ? m_den + 1 : m_den;
      else                   m_den = 0;
    end
  endtask

  task automatic check_table(input vec_t t, input int r);
    chk($sformatf("row%0d if_gnt", r),      32'(bus.if_gnt),      32'(t.e_ifg));
    chk($sformatf("row%0d ls_gnt", r),      32'(bus.ls_gnt),      32'(t.e_lsg));
    chk($sformatf("row%0d fetch_stall", r), 32'(bus.fetch_stall), 32'(t.e_stall));
    chk($sformatf("row%0d ram_en", r),      32'(bus.ram_en),      32'(t.e_en));
    chk($sformatf("row%0d ram_we", r),      32'(bus.ram_we),      32'(t.e_we));
    chk($sformatf("row%0d ram_din", r),     bus.ram_din,          t.e_din);
    if (t.chk_addr) chk($sformatf("row%0d ram_addr", r), 32'(bus.ram_addr), 32'(t.e_addr));
    chk($sformatf("row%0d if_rvalid", r),   32'(bus.if_rvalid),   32'(t.e_ifv));
    chk($sformatf("row%0d ls_rvalid", r),   32'(bus.ls_rvalid),   32'(t.e_lsv));
    if (t.chk_rd) begin
      chk($sformatf("row%0d if_rdata", r), bus.if_rdata, t.e_ifd);
      chk($sformatf("row%0d ls_rdata", r), bus.ls_rdata, t.e_lsd);
    end
  endtask

  task automatic check_model(input int n);
    logic gi, gl, ifv, lsv;
    model_grant(gi, gl);
    ifv = rst && (m_pend == 1);
    lsv = rst && (m_pend == 2);
    chk($sformatf("rnd%0d if_gnt", n),      32'(bus.if_gnt),      32'(gi));
    chk($sformatf("rnd%0d ls_gnt", n),      32'(bus.ls_gnt),      32'(gl));
    chk($sformatf("rnd%0d fetch_stall", n), 32'(bus.fetch_stall), 32'(bus.if_req && !gi));
    chk($sformatf("rnd%0d ram_en", n),      32'(bus.ram_en),      32'(gi || gl));
    chk($sformatf("rnd%0d ram_we", n),      32'(bus.ram_we),      32'(gl && bus.ls_we));
    chk($sformatf("rnd%0d ram_din", n),     bus.ram_din,          gl ? bus.ls_din : 32'd0);
    if (gi || gl)
      chk($sformatf("rnd%0d ram_addr", n), 32'(bus.ram_addr),
          32'(widx(gl ? bus.ls_addr : bus.if_addr)));
    chk($sformatf("rnd%0d if_rvalid", n),   32'(bus.if_rvalid),   32'(ifv));
    chk($sformatf("rnd%0d ls_rvalid", n),   32'(bus.ls_rvalid),   32'(lsv));
    chk($sformatf("rnd%0d if_rdata", n),    bus.if_rdata,         ifv ? m_pend_data : m_if_hold);
    chk($sformatf("rnd%0d ls_rdata", n),    bus.ls_rdata,         lsv ? m_pend_data : m_ls_hold);
  endtask

  initial begin
    vec_t idle;
    for (int i = 0; i < NWORDS; i++) model_mem[i] = init_word(i);
    m_den = 0; m_pend = 0; m_pend_data = 32'd0; m_if_hold = 32'd0; m_ls_hold = 32'd0;

    //          rst ifr ifa            lsr we lsa     ld      ifg lsg stl en we addr din    ifv ifd            lsv lsd
    tbl[0]  = v(0, 1, 'h8,           1, 0, 'h40, 0,      0, 0, 1, 0, 0, -1,  0,     0, 0,             0, 0);
    tbl[1]  = v(0, 1, 'h8,           1, 0, 'h40, 0,      0, 0, 1, 0, 0, -1,  0,     0, 0,             0, 0);
    tbl[2]  = v(1, 1, 'h8,           0, 0, 0,    0,      1, 0, 0, 1, 0, 2,   0,     0, 0,             0, 0);
    tbl[3]  = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     1, 'h0100_2223,   0, 0);
    tbl[4]  = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     0, 'h0100_2223,   0, 0);
    tbl[5]  = v(1, 1, 'h0,           1, 1, 'h4,  'h10,   0, 1, 1, 1, 1, 1,   'h10,  0, 'h0100_2223,   0, 0);
    tbl[6]  = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     0, 'h0100_2223,   0, 0);
    tbl[7]  = v(1, 1, 'h4,           0, 0, 0,    0,      1, 0, 0, 1, 0, 1,   0,     0, 'h0100_2223,   0, 0);
    tbl[8]  = v(1, 0, 0,             1, 0, 'h40, 0,      0, 1, 0, 1, 0, 16,  0,     1, 'h10,          0, 0);
    tbl[9]  = v(1, 1, 'h0,           0, 0, 0,    0,      1, 0, 0, 1, 0, 0,   0,     0, 'h10,          1, 'hA500_0010);
    tbl[10] = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     1, 'hA500_0000,   0, 'hA500_0010);
    tbl[11] = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     0, 'hA500_0000,   0, 'hA500_0010);
    tbl[12] = v(1, 1, 'hFFFF_C00B,   0, 0, 0,    0,      1, 0, 0, 1, 0, 2,   0,     0, 'hA500_0000,   0, 'hA500_0010);
    tbl[13] = v(0, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     0, 0,             0, 0);
    tbl[13].chk_rd = 1'b0;
    tbl[14] = v(1, 0, 0,             0, 0, 0,    0,      0, 0, 0, 0, 0, -1,  0,     0, 0,             0, 0);
    for (int k = 1; k <= 10; k++) begin
      int ifg, lsv;
      ifg = (k == 5 || k == 10) ? 1 : 0;
      lsv = (k >= 2 && k != 6) ? 1 : 0;
      tbl[14+k] = v(1, 1, 'h8, 1, 0, 'h40, 0, ifg, 1 - ifg, 1 - ifg, 1, 0, (ifg != 0) ? 2 : 16, 0,
                    (k == 6) ? 1 : 0, (k >= 6) ? 32'h0100_2223 : 32'd0,
                    lsv, (k >= 2) ? 32'hA500_0010 : 32'd0);
    end

    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
    drive(idle);
    @(posedge clk);
    model_step();
    #1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_table(tbl[i], i);
      @(posedge clk);
      model_step();
      #1;
    end

    for (int n = 0; n < NRAND; n++) begin
      rst         = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      bus.if_req  = ($urandom_range(0, 3) != 0);
      bus.if_addr = $urandom & 32'hFFFF_C03F;
      bus.ls_req  = ($urandom_range(0, 2) != 0);
      bus.ls_we   = ($urandom_range(0, 2) == 0);
      bus.ls_addr = $urandom & 32'hFFFF_C03F;
      bus.ls_din  = $urandom;
      @(negedge clk);
      check_model(n);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
